uart_rs232_tx_fifo: RTL and testbench
=====================================

// Module: uart_rs232_tx_fifo
// PURPOSE
// - UART transmitter, counterpart to the on-board UART receiver; sends bytes back to the HC-06 Bluetooth module.
// - Buffers bytes in a small FIFO, then serialises each as start, NBits data (LSB first), optional parity, stop.
// - Uses the same 16x oversampling Tick strobe from UART_BaudRate_generator as the receiver (BaudRate=325 @ 50 MHz -> 9600 baud).
// PARAMETERS
// - FIFO_AW     2    FIFO address width; depth = 2**FIFO_AW entries of 8 bits
// - OVERSAMPLE  16   Tick pulses per bit time
// PORTS
// - Clk      in   1  board clock, 50 MHz, all logic on posedge
// - Rst_n    in   1  synchronous active-low reset
// - Tick     in   1  one-Clk-wide baud strobe at 16x bit rate
// - TxEn     in   1  1 = start new frames from FIFO; 0 = hold after current frame
// - NBits    in   4  data bits per word; 5..8 valid, any other value treated as 8
// - TxData   in   8  byte to queue; bits above NBits ignored on the line
// - TxValid  in   1  TxData valid; byte accepted when TxValid && TxReady at posedge
// - TxReady  out  1  FIFO not full
// - Tx       out  1  serial line, registered, idle high
// - TxBusy   out  1  FSM not in IDLE
// - TxDone   out  1  one-Clk pulse at end of each stop bit
// BEHAVIOUR
// - Reset (Rst_n=0 at posedge): Tx=1, TxBusy=0, TxDone=0, FIFO empty (TxReady=1), FSM=IDLE, tick/bit counters=0.
// - Reset mid-frame aborts the frame. Tx returns high on that edge. Queued bytes are discarded.
// - FIFO: circular, FIFO_AW-bit pointers plus a count. A push when full is ignored and TxReady stays 0.
// - Same-cycle push and pop is legal when not empty and not full; the count is unchanged.
// - A push into an empty FIFO is poppable on the next cycle, not the same one.
// - FSM states: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
// - IDLE: if TxEn=1 and FIFO not empty at a posedge, on that edge:
//   - pop the head byte into the shift register;
//   - latch the effective NBits;
//   - clear the tick counter;
//   - enter START with Tx=0.
//   - This gives 1 Clk latency from the pop condition to the start bit on Tx.
// - Bit timing: each bit is held for exactly OVERSAMPLE Tick pulses. The tick counter advances only on Tick=1.
//   - The bit ends on the Clk edge of the 16th Tick. Tx then changes on that same edge.
// - DATA: shift LSB first and count bits 0..N-1. After bit N-1, go to PARITY (if compiled in), otherwise STOP.
// - STOP: Tx=1 for one bit time. On its final Tick edge, TxDone=1 for one cycle.
//   - If TxEn=1 and FIFO not empty on that same edge, pop immediately and enter START (back-to-back frames, no idle gap).
//   - Otherwise go to IDLE.
// - TxEn=0 mid-frame: the current frame completes normally; no new frame starts.
// - NBits and TxEn changes mid-frame do not affect the frame in flight.
// - Frame length 8N1 = 10 bit times = 160 Ticks.
// CONFIGURATION
// - UART_TX_PARITY_EN defined:
//   - PARITY state is inserted after DATA.
//   - Tx = even parity (XOR of the N data bits) for one bit time.
//   - 8E1 frame = 11 bit times.
// - UART_TX_PARITY_EN undefined: no PARITY state or logic; DATA goes straight to STOP.
// TESTING
// - Reset: Rst_n=0 for 3 cycles with TxValid=1 -> Tx=1, TxReady=1, TxBusy=0, TxDone=0, nothing queued.
// - Single byte, Tick every 4th Clk, NBits=8: push 8'h31 ->
//   - start bit;
//   - bits 1,0,0,0,1,1,0,0;
//   - stop bit;
//   - each bit lasts 64 Clk;
//   - TxDone pulses once, 640 Clk after start.
// - Back-to-back: push 8'h30, 8'h34 -> two frames with no idle gap; second start bit begins on the first frame's final stop Tick.
// - FIFO full: FIFO_AW=2, TxEn=0, push 5 bytes -> TxReady=0 after 4; 5th dropped; TxEn=1 -> exactly 4 frames, in order.
// - NBits=5 with 8'hFF: 5 data bits of 1, then stop -> 7 bit times. NBits=4'hF behaves as 8.
// - Reset mid-frame after 3 data bits -> Tx=1 on the next edge; no TxDone; FIFO empty.
// - UART_TX_PARITY_EN: 8'h31 -> parity bit 1; 8'h33 -> parity bit 0; frame 176 Ticks.

Source files
------------

// File: rtl/uart_rs232_tx_fifo_if.sv
// Byte-push channel into the UART transmitter FIFO (valid/ready handshake).
interface uart_rs232_tx_fifo_if;
  logic [7:0] TxData;
  logic       TxValid;
  logic       TxReady;

  modport master (output TxData, output TxValid, input TxReady);
  modport slave  (input TxData, input TxValid, output TxReady);
endinterface

// File: rtl/uart_rs232_tx_fifo.sv
// Buffered UART transmitter: FIFO feeding a start/data/[parity]/stop serialiser on a 16x Tick.
// Even parity bit is compiled in only when UART_TX_PARITY_EN is defined.
module uart_rs232_tx_fifo #(
  parameter int FIFO_AW    = 2,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 Clk,
  input  logic                 Rst_n,
  input  logic                 Tick,
  input  logic                 TxEn,
  input  logic [3:0]           NBits,
  uart_rs232_tx_fifo_if.slave  tx_if,
  output logic                 Tx,
  output logic                 TxBusy,
  output logic                 TxDone
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int TW    = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [TW-1:0]    TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [FIFO_AW:0] FIFO_FULL = (FIFO_AW + 1)'(DEPTH);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0]   count;
  logic               full;
  logic               empty;
  logic               push;
  logic [7:0]         head;

  state_t             state;
  state_t             state_n;
  logic [TW-1:0]      tick_cnt;
  logic [TW-1:0]      tick_n;
  logic [2:0]         bit_cnt;
  logic [2:0]         bit_n;
  logic [7:0]         shift_q;
  logic [7:0]         shift_n;
  logic [3:0]         nbits_q;
  logic [3:0]         nbits_n;
  logic               tx_q;
  logic               tx_n;
  logic               done_q;
  logic               done_n;
  logic               load;
  logic               bit_end;
  logic               last_bit;
  logic               can_start;
  logic [3:0]         eff_nbits;

`ifdef UART_TX_PARITY_EN
  logic               par_q;
  logic               par_n;
  logic [7:0]         data_mask;
`endif

  assign full          = (count == FIFO_FULL);
  assign empty         = (count == '0);
  assign push          = tx_if.TxValid && !full;
  assign head          = mem[rd_ptr];
  assign tx_if.TxReady = !full;

  // Popping is gated on the registered count, so a byte pushed into an
  // empty FIFO only becomes visible to the serialiser one cycle later.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (load) rd_ptr <= rd_ptr + 1'b1;
      case ({push, load})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst_n && push) mem[wr_ptr] <= tx_if.TxData;
  end

  assign eff_nbits = (NBits >= 4'd5 && NBits <= 4'd8) ? NBits : 4'd8;
  assign bit_end   = Tick && (tick_cnt == TICK_LAST);
  assign last_bit  = ({1'b0, bit_cnt} == (nbits_q - 4'd1));
  assign can_start = TxEn && !empty;

`ifdef UART_TX_PARITY_EN
  assign data_mask = 8'hFF >> (4'd8 - eff_nbits);
`endif

  always_comb begin
    state_n = state;
    tick_n  = tick_cnt;
    bit_n   = bit_cnt;
    shift_n = shift_q;
    nbits_n = nbits_q;
    tx_n    = tx_q;
    done_n  = 1'b0;
    load    = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_n   = par_q;
`endif

    if (state != IDLE && Tick) tick_n = bit_end ? '0 : tick_cnt + 1'b1;

    case (state)
      IDLE: load = can_start;
      START: begin
        if (bit_end) begin
          state_n = DATA;
          bit_n   = 3'd0;
          tx_n    = shift_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (last_bit) begin
`ifdef UART_TX_PARITY_EN
            state_n = PARITY;
            tx_n    = par_q;
`else
            state_n = STOP;
            tx_n    = 1'b1;
`endif
          end else begin
            bit_n   = bit_cnt + 3'd1;
            shift_n = {1'b0, shift_q[7:1]};
            tx_n    = shift_q[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_n = STOP;
          tx_n    = 1'b1;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          done_n = 1'b1;
          if (can_start) load = 1'b1;
          else           state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    // Frame setup shared by the idle start and the back-to-back start from STOP.
    if (load) begin
      state_n = START;
      shift_n = head;
      nbits_n = eff_nbits;
      tick_n  = '0;
      bit_n   = 3'd0;
      tx_n    = 1'b0;
`ifdef UART_TX_PARITY_EN
      par_n   = ^(head & data_mask);
`endif
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state    <= IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shift_q  <= '0;
      nbits_q  <= 4'd8;
      tx_q     <= 1'b1;
      done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      tick_cnt <= tick_n;
      bit_cnt  <= bit_n;
      shift_q  <= shift_n;
      nbits_q  <= nbits_n;
      tx_q     <= tx_n;
      done_q   <= done_n;
`ifdef UART_TX_PARITY_EN
      par_q    <= par_n;
`endif
    end
  end

  assign Tx     = tx_q;
  assign TxDone = done_q;
  assign TxBusy = (state != IDLE);

endmodule

// File: tb/tb_uart_rs232_tx_fifo.sv
// Directed and randomized bench for uart_rs232_tx_fifo; expected frames are rebuilt from the byte,
// the effective word length and the optional even parity, then compared bit by bit on the Tick grid.
module tb_uart_rs232_tx_fifo;
  localparam int OS = 16;
  localparam int AW = 2;
`ifdef UART_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif

  logic       Clk   = 1'b0;
  logic       Rst_n = 1'b0;
  logic       Tick  = 1'b0;
  logic       TxEn  = 1'b0;
  logic [3:0] NBits = 4'd8;
  logic       Tx;
  logic       TxBusy;
  logic       TxDone;

  int n_assert = 0;
  int n_fail   = 0;
  int tick_period = 4;
  int tphase = 0;
  int w, t, w2, t2;

  uart_rs232_tx_fifo_if bus ();

  uart_rs232_tx_fifo #(.FIFO_AW(AW), .OVERSAMPLE(OS)) dut (
    .Clk    (Clk),
    .Rst_n  (Rst_n),
    .Tick   (Tick),
    .TxEn   (TxEn),
    .NBits  (NBits),
    .tx_if  (bus),
    .Tx     (Tx),
    .TxBusy (TxBusy),
    .TxDone (TxDone)
  );

  always #5 Clk = ~Clk;

  initial begin
    forever begin
      @(negedge Clk);
      tphase = (tphase + 1 >= tick_period) ? 0 : tphase + 1;
      Tick = (tphase == 0);
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int eff_nb(input logic [3:0] nb);
    return (nb >= 5 && nb <= 8) ? int'(nb) : 8;
  endfunction

  // Waits for the start bit, then walks every expected bit: value held for 16 Ticks,
  // change exactly on the 16th Tick edge, TxDone only on the final stop Tick.
  task automatic check_frame(input logic [7:0] data, input logic [3:0] nb, input bit aligned,
                             output int waited, output int total);
    bit q[$];
    int n = eff_nb(nb);
    int ones = 0;
    bit early_done = 0;
    q.push_back(1'b0);
    for (int i = 0; i < n; i++) begin
      q.push_back(data[i]);
      ones += int'(data[i]);
    end
    if (PB == 1) q.push_back(ones % 2 == 1);
    q.push_back(1'b1);
    waited = 0;
    while (Tx !== 1'b0 && waited < 4000) begin
      @(posedge Clk); #1;
      waited++;
    end
    chk("start_seen", Tx, 0);
    total = 0;
    for (int k = 0; k < q.size(); k++) begin
      bit ok = (Tx === q[k]);
      int ticks = 0;
      int cyc = 0;
      while (ticks < OS && cyc < OS * tick_period + 40) begin
        @(posedge Clk); #1;
        cyc++;
        if (Tick === 1'b1) ticks++;
        if (ticks < OS) begin
          if (Tx !== q[k]) ok = 0;
          if (TxDone !== 1'b0) early_done = 1;
        end
      end
      total += cyc;
      chk($sformatf("bit%0d_of_%02h", k, data), (ok && ticks == OS), 1);
      if (k > 0 || aligned) chk($sformatf("bit%0d_len_%02h", k, data), cyc, OS * tick_period);
    end
    chk("done_pulse", TxDone, 1);
    chk("no_early_done", early_done, 0);
  endtask

  task automatic push_wait(input logic [7:0] d);
    bit acc = 0;
    int n = 0;
    while (!acc && n < 5000) begin
      @(negedge Clk); #1;
      bus.TxData  = d;
      bus.TxValid = 1'b1;
      acc = (bus.TxReady === 1'b1);
      @(posedge Clk); #1;
      n++;
    end
    bus.TxValid = 1'b0;
    chk("push_accepted", acc, 1);
  endtask

  task automatic align_tick();
    int n = 0;
    do begin
      @(negedge Clk); #1;
      n++;
    end while (Tick !== 1'b1 && n < 100);
  endtask

  initial begin
    int n;
    int ticks;
    bit flag;
    logic [7:0] fb [5];
    logic [7:0] rb [6];

    // Reset with a push pending: nothing may be queued.
    bus.TxData  = 8'hAA;
    bus.TxValid = 1'b1;
    TxEn = 1'b1;
    Rst_n = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_tx", Tx, 1);
    chk("rst_ready", bus.TxReady, 1);
    chk("rst_busy", TxBusy, 0);
    chk("rst_done", TxDone, 0);
    @(negedge Clk); #1;
    bus.TxValid = 1'b0;
    Rst_n = 1'b1;
    flag = 0;
    repeat (60) begin
      @(posedge Clk); #1;
      if (TxBusy !== 1'b0 || Tx !== 1'b1) flag = 1;
    end
    chk("rst_nothing_queued", flag, 0);

    // Single 0x31, Tick every 4th Clk: start one Clk after the pop condition.
    TxEn = 1'b0;
    push_wait(8'h31);
    align_tick();
    TxEn = 1'b1;
    check_frame(8'h31, 4'd8, 1, w, t);
    chk("single_latency", w, 1);
    chk("single_done_time", t, (10 + PB) * OS * 4);
    chk("single_idle_after", TxBusy, 0);

    // Back-to-back frames with no idle gap.
    TxEn = 1'b0;
    push_wait(8'h30);
    push_wait(8'h34);
    align_tick();
    TxEn = 1'b1;
    check_frame(8'h30, 4'd8, 1, w, t);
    chk("b2b_latency", w, 1);
    check_frame(8'h34, 4'd8, 1, w, t);
    chk("b2b_gap", w, 0);

    // FIFO full: 5th push dropped, 4 frames in order.
    TxEn = 1'b0;
    fb = '{8'h11, 8'h22, 8'hC3, 8'h44, 8'h5E};
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk); #1;
      bus.TxData  = fb[i];
      bus.TxValid = 1'b1;
      @(posedge Clk); #1;
      if (i == 2) chk("full_ready_after3", bus.TxReady, 1);
      if (i == 3) chk("full_ready_after4", bus.TxReady, 0);
    end
    bus.TxValid = 1'b0;
    chk("full_ready_after5", bus.TxReady, 0);
    @(negedge Clk); #1;
    TxEn = 1'b1;
    for (int i = 0; i < 4; i++) check_frame(fb[i], 4'd8, 0, w, t);
    flag = 0;
    repeat (400) begin
      @(posedge Clk); #1;
      if (TxBusy !== 1'b0 || Tx !== 1'b1) flag = 1;
    end
    chk("full_fifth_dropped", flag, 0);
    chk("full_ready_drained", bus.TxReady, 1);

    // Push into an empty FIFO with TxEn=1 starts one cycle after the push edge.
    NBits = 4'd5;
    push_wait(8'hFF);
    check_frame(8'hFF, 4'd5, 0, w, t);
    chk("push_to_start", w, 1);
    NBits = 4'hF;
    push_wait(8'h5A);
    check_frame(8'h5A, 4'hF, 0, w, t);
    NBits = 4'd8;
    push_wait(8'h33);
    check_frame(8'h33, 4'd8, 0, w, t);

    // NBits/TxEn changed mid-frame: frame unaffected, next frame waits for TxEn.
    TxEn = 1'b0;
    push_wait(8'hA5);
    push_wait(8'h1F);
    align_tick();
    TxEn = 1'b1;
    fork
      check_frame(8'hA5, 4'd8, 1, w, t);
      begin
        repeat (100) @(negedge Clk);
        #1;
        NBits = 4'd5;
        TxEn  = 1'b0;
      end
    join
    flag = 0;
    repeat (200) begin
      @(posedge Clk); #1;
      if (TxBusy !== 1'b0) flag = 1;
    end
    chk("txen_hold", flag, 0);
    @(negedge Clk); #1;
    TxEn = 1'b1;
    check_frame(8'h1F, 4'd5, 0, w, t);

    // Reset after 3 data bits: line high at once, no TxDone, queue discarded.
    TxEn = 1'b0;
    NBits = 4'd8;
    push_wait(8'h31);
    push_wait(8'h55);
    push_wait(8'h66);
    align_tick();
    TxEn = 1'b1;
    n = 0;
    while (Tx !== 1'b0 && n < 500) begin
      @(posedge Clk); #1;
      n++;
    end
    ticks = 0;
    n = 0;
    while (ticks < 4 * OS && n < 2000) begin
      @(posedge Clk); #1;
      n++;
      if (Tick === 1'b1) ticks++;
    end
    chk("rst_mid_bit3", Tx, 0);
    repeat (2) @(posedge Clk);
    @(negedge Clk); #1;
    Rst_n = 1'b0;
    @(posedge Clk); #1;
    chk("rst_mid_tx", Tx, 1);
    chk("rst_mid_busy", TxBusy, 0);
    chk("rst_mid_done", TxDone, 0);
    chk("rst_mid_ready", bus.TxReady, 1);
    @(negedge Clk); #1;
    Rst_n = 1'b1;
    flag = 0;
    repeat (1500) begin
      @(posedge Clk); #1;
      if (Tx !== 1'b1 || TxBusy !== 1'b0 || TxDone !== 1'b0) flag = 1;
    end
    chk("rst_mid_flushed", flag, 0);

    // Random bursts: random bytes, word lengths, Tick rates and push gaps.
    for (int b = 0; b < 3; b++) begin
      @(negedge Clk); #1;
      NBits = 4'($urandom_range(0, 15));
      tick_period = $urandom_range(1, 3);
      for (int i = 0; i < 6; i++) rb[i] = 8'($urandom);
      TxEn = 1'b1;
      fork
        begin
          for (int i = 0; i < 6; i++) begin
            repeat ($urandom_range(0, 20)) @(posedge Clk);
            push_wait(rb[i]);
          end
        end
        begin
          for (int j = 0; j < 6; j++) check_frame(rb[j], NBits, 0, w2, t2);
        end
      join
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
